// File: rtl/pipe_ctrl.sv
// pipe_ctrl: in-order pipeline valid/stall controller with register-hazard detection.
// Define PIPE_CTRL_BYPASS_EN to forward youngest producer values; otherwise any in-flight match stalls stage 0.

module pipe_ctrl #(
    parameter int STAGES = 5,
    parameter int BUS_W  = 64,
    parameter int RF_AW  = 5
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     cancel,
    input  logic                     in_valid,
    input  logic [BUS_W-1:0]         in_bus,
    output logic                     in_ready,
    input  logic [STAGES-1:0]        stage_over,
    input  logic [STAGES*BUS_W-1:0]  stage_nbus,
    output logic [STAGES-1:0]        stage_valid,
    output logic [STAGES*BUS_W-1:0]  stage_bus,
    output logic                     retire_valid,
    input  logic                     retire_ready,
    output logic [BUS_W-1:0]         retire_bus,
    input  logic [STAGES-1:0]        stage_wen,
    input  logic [STAGES-1:0]        stage_wready,
    input  logic [STAGES*RF_AW-1:0]  stage_wdest,
    input  logic [STAGES*32-1:0]     stage_wvalue,
    input  logic [RF_AW-1:0]         rs,
    input  logic [RF_AW-1:0]         rt,
    output logic                     rs_hit,
    output logic                     rt_hit,
    output logic [31:0]              rs_value,
    output logic [31:0]              rt_value,
    output logic                     hazard_stall,
    output logic [31:0]              stall_cnt
);

    logic [STAGES-1:0] over_eff;
    logic [STAGES:0]   allow;
    logic [STAGES-1:0] rs_match;
    logic [STAGES-1:0] rt_match;
    logic              rs_found;
    logic              rt_found;
    logic              unused_inputs;

    // Stage 0 is never a producer; it is the consumer whose sources are being decoded.
    always_comb begin
        rs_match = '0;
        rt_match = '0;
        for (int k = 1; k < STAGES; k++) begin
            rs_match[k] = stage_valid[k] & stage_wen[k] &
                          (stage_wdest[k*RF_AW +: RF_AW] == rs) & (rs != '0);
            rt_match[k] = stage_valid[k] & stage_wen[k] &
                          (stage_wdest[k*RF_AW +: RF_AW] == rt) & (rt != '0);
        end
    end

`ifdef PIPE_CTRL_BYPASS_EN
    logic        rs_win_ready;
    logic        rt_win_ready;
    logic [31:0] rs_win_value;
    logic [31:0] rt_win_value;

    // Lowest-numbered matching stage is the youngest producer and wins.
    always_comb begin
        rs_found     = 1'b0;
        rt_found     = 1'b0;
        rs_win_ready = 1'b0;
        rt_win_ready = 1'b0;
        rs_win_value = '0;
        rt_win_value = '0;
        for (int k = 1; k < STAGES; k++) begin
            if (rs_match[k] && !rs_found) begin
                rs_found     = 1'b1;
                rs_win_ready = stage_wready[k];
                rs_win_value = stage_wvalue[k*32 +: 32];
            end
            if (rt_match[k] && !rt_found) begin
                rt_found     = 1'b1;
                rt_win_ready = stage_wready[k];
                rt_win_value = stage_wvalue[k*32 +: 32];
            end
        end
    end

    assign rs_hit       = rs_found;
    assign rt_hit       = rt_found;
    assign rs_value     = rs_win_value;
    assign rt_value     = rt_win_value;
    assign hazard_stall = stage_valid[0] &
                          ((rs_found & ~rs_win_ready) | (rt_found & ~rt_win_ready));
    assign unused_inputs = ^{stage_wen[0], stage_wdest[RF_AW-1:0],
                             stage_wready[0], stage_wvalue[31:0]};
`else
    assign rs_found      = |rs_match;
    assign rt_found      = |rt_match;
    assign rs_hit        = 1'b0;
    assign rt_hit        = 1'b0;
    assign rs_value      = '0;
    assign rt_value      = '0;
    assign hazard_stall  = stage_valid[0] & (rs_found | rt_found);
    assign unused_inputs = ^{stage_wen[0], stage_wdest[RF_AW-1:0],
                             stage_wready, stage_wvalue};
`endif

    // allow[k]: stage k may load this cycle because it is empty or its payload is leaving.
    always_comb begin
        over_eff    = stage_over;
        over_eff[0] = stage_over[0] & ~hazard_stall;
        allow       = '0;
        allow[STAGES] = retire_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            allow[k] = ~stage_valid[k] | (over_eff[k] & allow[k+1]);
        end
    end

    assign in_ready     = allow[0] | cancel;
    assign retire_valid = stage_valid[STAGES-1] & stage_over[STAGES-1];
    assign retire_bus   = stage_nbus[(STAGES-1)*BUS_W +: BUS_W];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stage_valid <= '0;
            stall_cnt   <= '0;
        end else begin
            if (hazard_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (cancel) begin
                stage_valid <= '0;
            end else begin
                if (allow[0]) begin
                    stage_valid[0] <= in_valid;
                end
                for (int k = 1; k < STAGES; k++) begin
                    if (allow[k]) begin
                        stage_valid[k] <= stage_valid[k-1] & over_eff[k-1];
                    end
                end
            end
        end
    end

    // Payload registers need no reset: they are only observed alongside their valid bit.
    always_ff @(posedge clk) begin
        if (resetn && !cancel) begin
            if (allow[0] && in_valid) begin
                stage_bus[0 +: BUS_W] <= in_bus;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (allow[k] && stage_valid[k-1] && over_eff[k-1]) begin
                    stage_bus[k*BUS_W +: BUS_W] <= stage_nbus[(k-1)*BUS_W +: BUS_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a randomized run against a queue-style model.
// Expectations follow the PIPE_CTRL_BYPASS_EN setting of the build.

module tb_pipe_ctrl;

    localparam int STAGES = 5;
    localparam int BUS_W  = 64;
    localparam int RF_AW  = 5;
`ifdef PIPE_CTRL_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                    clk;
    logic                    resetn;
    logic                    cancel;
    logic                    in_valid;
    logic [BUS_W-1:0]        in_bus;
    logic                    in_ready;
    logic [STAGES-1:0]       stage_over;
    logic [STAGES*BUS_W-1:0] stage_nbus;
    logic [STAGES-1:0]       stage_valid;
    logic [STAGES*BUS_W-1:0] stage_bus;
    logic                    retire_valid;
    logic                    retire_ready;
    logic [BUS_W-1:0]        retire_bus;
    logic [STAGES-1:0]       stage_wen;
    logic [STAGES-1:0]       stage_wready;
    logic [STAGES*RF_AW-1:0] stage_wdest;
    logic [STAGES*32-1:0]    stage_wvalue;
    logic [RF_AW-1:0]        rs;
    logic [RF_AW-1:0]        rt;
    logic                    rs_hit;
    logic                    rt_hit;
    logic [31:0]             rs_value;
    logic [31:0]             rt_value;
    logic                    hazard_stall;
    logic [31:0]             stall_cnt;

    int checks   = 0;
    int failures = 0;

    pipe_ctrl #(.STAGES(STAGES), .BUS_W(BUS_W), .RF_AW(RF_AW)) dut (
        .clk(clk), .resetn(resetn), .cancel(cancel),
        .in_valid(in_valid), .in_bus(in_bus), .in_ready(in_ready),
        .stage_over(stage_over), .stage_nbus(stage_nbus),
        .stage_valid(stage_valid), .stage_bus(stage_bus),
        .retire_valid(retire_valid), .retire_ready(retire_ready), .retire_bus(retire_bus),
        .stage_wen(stage_wen), .stage_wready(stage_wready),
        .stage_wdest(stage_wdest), .stage_wvalue(stage_wvalue),
        .rs(rs), .rt(rt), .rs_hit(rs_hit), .rt_hit(rt_hit),
        .rs_value(rs_value), .rt_value(rt_value),
        .hazard_stall(hazard_stall), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BUS_W-1:0] nb_const(int k);
        return 64'h0000_1000 + 64'(k);
    endfunction

    task automatic idle_inputs;
        resetn       = 1'b1;
        cancel       = 1'b0;
        in_valid     = 1'b0;
        in_bus       = '0;
        stage_over   = '1;
        retire_ready = 1'b1;
        stage_wen    = '0;
        stage_wready = '1;
        stage_wdest  = '0;
        stage_wvalue = '0;
        rs           = '0;
        rt           = '0;
        for (int k = 0; k < STAGES; k++) stage_nbus[k*BUS_W +: BUS_W] = nb_const(k);
    endtask

    task automatic test_reset;
        idle_inputs();
        resetn   = 1'b0;
        in_valid = 1'b1;
        tick();
        tick();
        checks++;
        if (stage_valid !== '0) begin
            failures++; $display("[TB] FAIL reset_valid: got %b expected 0", stage_valid);
        end
        checks++;
        if (stall_cnt !== 32'd0) begin
            failures++; $display("[TB] FAIL reset_cnt: got %0d expected 0", stall_cnt);
        end
        checks++;
        if (retire_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_retire: got %b expected 0", retire_valid);
        end
        checks++;
        if (hazard_stall !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_hazard: got %b expected 0", hazard_stall);
        end
    endtask

    task automatic test_fill;
        int lat;
        idle_inputs();
        in_valid = 1'b1;
        in_bus   = 64'h1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL fill_in_ready: got %b expected 1", in_ready);
        end
        lat = 0;
        do begin
            tick();
            lat++;
        end while (retire_valid !== 1'b1 && lat < 20);
        checks++;
        if (lat != 5) begin
            failures++; $display("[TB] FAIL fill_latency: got %0d expected 5", lat);
        end
        checks++;
        if (retire_bus !== nb_const(STAGES-1)) begin
            failures++; $display("[TB] FAIL fill_retire_bus: got %h expected %h", retire_bus, nb_const(STAGES-1));
        end
        checks++;
        if (stage_bus[0 +: BUS_W] !== 64'h1) begin
            failures++; $display("[TB] FAIL fill_bus0: got %h expected 1", stage_bus[0 +: BUS_W]);
        end
        checks++;
        if (stage_bus[2*BUS_W +: BUS_W] !== nb_const(1)) begin
            failures++; $display("[TB] FAIL fill_bus2: got %h expected %h", stage_bus[2*BUS_W +: BUS_W], nb_const(1));
        end
    endtask

    task automatic test_backpressure;
        logic [BUS_W-1:0] exp_bus;
        retire_ready = 1'b0;
        in_bus = 64'h2;
        for (int k = 0; k < STAGES; k++) stage_nbus[k*BUS_W +: BUS_W] = nb_const(k) + 64'h100;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                failures++; $display("[TB] FAIL bp_in_ready: got %b expected 0", in_ready);
            end
            tick();
            checks++;
            if (stage_valid !== 5'b11111) begin
                failures++; $display("[TB] FAIL bp_valid: got %b expected 11111", stage_valid);
            end
            for (int k = 0; k < STAGES; k++) begin
                exp_bus = (k == 0) ? 64'h1 : nb_const(k-1);
                checks++;
                if (stage_bus[k*BUS_W +: BUS_W] !== exp_bus) begin
                    failures++; $display("[TB] FAIL bp_bus%0d: got %h expected %h", k, stage_bus[k*BUS_W +: BUS_W], exp_bus);
                end
            end
        end
        retire_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL bp_resume_ready: got %b expected 1", in_ready);
        end
        tick();
        checks++;
        if (stage_valid !== 5'b11111 || stage_bus[0 +: BUS_W] !== 64'h2 ||
            stage_bus[BUS_W +: BUS_W] !== nb_const(0) + 64'h100) begin
            failures++; $display("[TB] FAIL bp_resume: got valid=%b bus0=%h bus1=%h expected 11111/2/%h",
                                 stage_valid, stage_bus[0 +: BUS_W], stage_bus[BUS_W +: BUS_W], nb_const(0) + 64'h100);
        end
    endtask

    task automatic test_forward;
        in_valid = 1'b0;
        stage_wen[2] = 1'b1; stage_wdest[2*RF_AW +: RF_AW] = 5'd8;
        stage_wvalue[2*32 +: 32] = 32'hDEAD; stage_wready[2] = 1'b1;
        stage_wen[3] = 1'b1; stage_wdest[3*RF_AW +: RF_AW] = 5'd8;
        stage_wvalue[3*32 +: 32] = 32'hBEEF; stage_wready[3] = 1'b0;
        rs = 5'd8; rt = 5'd0;
        #1;
        checks++;
        if (rs_hit !== BYPASS || rs_value !== (BYPASS ? 32'hDEAD : 32'h0)) begin
            failures++; $display("[TB] FAIL fwd_rs: got hit=%b val=%h expected %b/%h", rs_hit, rs_value, BYPASS, BYPASS ? 32'hDEAD : 32'h0);
        end
        checks++;
        if (hazard_stall !== !BYPASS) begin
            failures++; $display("[TB] FAIL fwd_hazard: got %b expected %b", hazard_stall, !BYPASS);
        end
        checks++;
        if (rt_hit !== 1'b0 || rt_value !== 32'h0) begin
            failures++; $display("[TB] FAIL fwd_rt_zero: got hit=%b val=%h expected 0/0", rt_hit, rt_value);
        end
        rs = 5'd0; rt = 5'd8;
        #1;
        checks++;
        if (rt_hit !== BYPASS || rt_value !== (BYPASS ? 32'hDEAD : 32'h0)) begin
            failures++; $display("[TB] FAIL fwd_rt: got hit=%b val=%h expected %b/%h", rt_hit, rt_value, BYPASS, BYPASS ? 32'hDEAD : 32'h0);
        end
        // Not-ready youngest producer in stage 1; address 0 must never stall.
        stage_wen = '0; stage_wen[1] = 1'b1; stage_wready[1] = 1'b0;
        stage_wdest[1*RF_AW +: RF_AW] = 5'd0; stage_wvalue[1*32 +: 32] = 32'h1234;
        rs = 5'd0; rt = 5'd0;
        #1;
        checks++;
        if (hazard_stall !== 1'b0 || rs_hit !== 1'b0) begin
            failures++; $display("[TB] FAIL fwd_addr0: got stall=%b hit=%b expected 0/0", hazard_stall, rs_hit);
        end
        stage_wdest[1*RF_AW +: RF_AW] = 5'd8; rs = 5'd8;
        #1;
        checks++;
        if (hazard_stall !== 1'b1) begin
            failures++; $display("[TB] FAIL fwd_stall: got %b expected 1", hazard_stall);
        end
        checks++;
        if (rs_hit !== BYPASS || rs_value !== (BYPASS ? 32'h1234 : 32'h0)) begin
            failures++; $display("[TB] FAIL fwd_stall_rs: got hit=%b val=%h expected %b/%h", rs_hit, rs_value, BYPASS, BYPASS ? 32'h1234 : 32'h0);
        end
        tick();
        checks++;
        if (stall_cnt !== 32'd1) begin
            failures++; $display("[TB] FAIL fwd_cnt: got %0d expected 1", stall_cnt);
        end
        checks++;
        if (stage_valid !== 5'b11101 || stage_bus[0 +: BUS_W] !== 64'h2) begin
            failures++; $display("[TB] FAIL fwd_hold: got valid=%b bus0=%h expected 11101/2", stage_valid, stage_bus[0 +: BUS_W]);
        end
        checks++;
        if (hazard_stall !== 1'b0) begin
            failures++; $display("[TB] FAIL fwd_release: got %b expected 0", hazard_stall);
        end
    endtask

    task automatic test_cancel;
        stage_wen = '0; rs = '0; rt = '0;
        in_valid = 1'b1; in_bus = 64'h3;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (stage_valid !== 5'b11111) begin
            failures++; $display("[TB] FAIL cancel_prefill: got %b expected 11111", stage_valid);
        end
        cancel = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || retire_valid !== 1'b1) begin
            failures++; $display("[TB] FAIL cancel_same_cycle: got ready=%b retire=%b expected 1/1", in_ready, retire_valid);
        end
        tick();
        cancel = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (stage_valid !== '0 || retire_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL cancel_flush: got valid=%b retire=%b expected 0/0", stage_valid, retire_valid);
        end
        checks++;
        if (stall_cnt !== 32'd1) begin
            failures++; $display("[TB] FAIL cancel_cnt: got %0d expected 1", stall_cnt);
        end
    endtask

    task automatic test_reset_midstall;
        in_valid = 1'b1; in_bus = 64'h4;
        for (int i = 0; i < 5; i++) tick();
        stage_over[1] = 1'b0;
        stage_wen[1] = 1'b1; stage_wready[1] = 1'b0;
        stage_wdest[1*RF_AW +: RF_AW] = 5'd8; rs = 5'd8;
        tick();
        tick();
        checks++;
        if (stall_cnt !== 32'd3) begin
            failures++; $display("[TB] FAIL midstall_cnt: got %0d expected 3", stall_cnt);
        end
        checks++;
        if (stage_valid !== 5'b10011) begin
            failures++; $display("[TB] FAIL midstall_valid: got %b expected 10011", stage_valid);
        end
        resetn = 1'b0;
        tick();
        checks++;
        if (stage_valid !== '0 || stall_cnt !== 32'd0) begin
            failures++; $display("[TB] FAIL midstall_reset: got valid=%b cnt=%0d expected 0/0", stage_valid, stall_cnt);
        end
        resetn = 1'b1; stage_over = '1; stage_wen = '0; in_valid = 1'b1; in_bus = 64'h5;
        tick();
        checks++;
        if (stage_valid !== 5'b00001 || stage_bus[0 +: BUS_W] !== 64'h5) begin
            failures++; $display("[TB] FAIL midstall_reentry: got valid=%b bus0=%h expected 00001/5", stage_valid, stage_bus[0 +: BUS_W]);
        end
    endtask

    // Model: per-stage occupancy arrays; movement resolved from the retire end toward stage 0.
    task automatic test_random;
        bit               m_valid [STAGES];
        logic [BUS_W-1:0] m_bus   [STAGES];
        logic [31:0]      m_cnt;
        bit               leaves  [STAGES];
        bit               room    [STAGES];
        bit               space, e_hz, e_rs_hit, e_rt_hit;
        logic [31:0]      e_rs_val, e_rt_val;
        logic [STAGES-1:0] e_valid;
        int               rs_k, rt_k;

        idle_inputs();
        resetn = 1'b0;
        tick();
        for (int k = 0; k < STAGES; k++) begin m_valid[k] = 1'b0; m_bus[k] = '0; end
        m_cnt = '0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            resetn       = ($urandom_range(0, 99) != 0);
            cancel       = ($urandom_range(0, 29) == 0);
            in_valid     = ($urandom_range(0, 9) < 7);
            in_bus       = {$urandom(), $urandom()};
            retire_ready = ($urandom_range(0, 3) != 0);
            rs           = RF_AW'($urandom_range(0, 3));
            rt           = RF_AW'($urandom_range(0, 3));
            for (int k = 0; k < STAGES; k++) begin
                stage_over[k]   = ($urandom_range(0, 3) != 0);
                stage_wen[k]    = $urandom_range(0, 1) == 1;
                stage_wready[k] = $urandom_range(0, 1) == 1;
                stage_wdest[k*RF_AW +: RF_AW] = RF_AW'($urandom_range(0, 3));
                stage_wvalue[k*32 +: 32]      = $urandom();
                stage_nbus[k*BUS_W +: BUS_W]  = {$urandom(), $urandom()};
            end
            #1;

            rs_k = 0; rt_k = 0;
            for (int k = STAGES - 1; k >= 1; k--) begin
                if (m_valid[k] && stage_wen[k] && rs != 0 && stage_wdest[k*RF_AW +: RF_AW] == rs) rs_k = k;
                if (m_valid[k] && stage_wen[k] && rt != 0 && stage_wdest[k*RF_AW +: RF_AW] == rt) rt_k = k;
            end
            e_rs_hit = BYPASS && rs_k != 0;
            e_rt_hit = BYPASS && rt_k != 0;
            e_rs_val = 32'h0; e_rt_val = 32'h0;
            if (e_rs_hit) e_rs_val = stage_wvalue[rs_k*32 +: 32];
            if (e_rt_hit) e_rt_val = stage_wvalue[rt_k*32 +: 32];
            if (BYPASS)
                e_hz = m_valid[0] && ((rs_k != 0 && !stage_wready[rs_k]) || (rt_k != 0 && !stage_wready[rt_k]));
            else
                e_hz = m_valid[0] && (rs_k != 0 || rt_k != 0);

            space = retire_ready;
            for (int k = STAGES - 1; k >= 0; k--) begin
                leaves[k] = m_valid[k] && stage_over[k] && !(k == 0 && e_hz) && space;
                room[k]   = !m_valid[k] || leaves[k];
                space     = room[k];
            end
            for (int k = 0; k < STAGES; k++) e_valid[k] = m_valid[k];

            checks++;
            if (stage_valid !== e_valid) begin
                failures++; $display("[TB] FAIL rnd_valid @%0d: got %b expected %b", cyc, stage_valid, e_valid);
            end
            for (int k = 0; k < STAGES; k++) begin
                if (m_valid[k]) begin
                    checks++;
                    if (stage_bus[k*BUS_W +: BUS_W] !== m_bus[k]) begin
                        failures++; $display("[TB] FAIL rnd_bus%0d @%0d: got %h expected %h", k, cyc, stage_bus[k*BUS_W +: BUS_W], m_bus[k]);
                    end
                end
            end
            checks++;
            if (in_ready !== (room[0] || cancel)) begin
                failures++; $display("[TB] FAIL rnd_in_ready @%0d: got %b expected %b", cyc, in_ready, room[0] || cancel);
            end
            checks++;
            if (retire_valid !== (m_valid[STAGES-1] && stage_over[STAGES-1]) ||
                retire_bus !== stage_nbus[(STAGES-1)*BUS_W +: BUS_W]) begin
                failures++; $display("[TB] FAIL rnd_retire @%0d: got %b/%h expected %b/%h", cyc, retire_valid, retire_bus,
                                     m_valid[STAGES-1] && stage_over[STAGES-1], stage_nbus[(STAGES-1)*BUS_W +: BUS_W]);
            end
            checks++;
            if (hazard_stall !== e_hz) begin
                failures++; $display("[TB] FAIL rnd_hazard @%0d: got %b expected %b", cyc, hazard_stall, e_hz);
            end
            checks++;
            if (rs_hit !== e_rs_hit || rs_value !== e_rs_val || rt_hit !== e_rt_hit || rt_value !== e_rt_val) begin
                failures++; $display("[TB] FAIL rnd_fwd @%0d: got %b/%h %b/%h expected %b/%h %b/%h", cyc,
                                     rs_hit, rs_value, rt_hit, rt_value, e_rs_hit, e_rs_val, e_rt_hit, e_rt_val);
            end
            checks++;
            if (stall_cnt !== m_cnt) begin
                failures++; $display("[TB] FAIL rnd_cnt @%0d: got %0d expected %0d", cyc, stall_cnt, m_cnt);
            end

            if (!resetn) begin
                for (int k = 0; k < STAGES; k++) m_valid[k] = 1'b0;
                m_cnt = '0;
            end else begin
                if (e_hz && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (cancel) begin
                    for (int k = 0; k < STAGES; k++) m_valid[k] = 1'b0;
                end else begin
                    for (int k = STAGES - 1; k >= 1; k--) begin
                        if (room[k]) begin
                            m_valid[k] = leaves[k-1];
                            if (leaves[k-1]) m_bus[k] = stage_nbus[(k-1)*BUS_W +: BUS_W];
                        end
                    end
                    if (room[0]) begin
                        m_valid[0] = in_valid;
                        if (in_valid) m_bus[0] = in_bus;
                    end
                end
            end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fill();
        test_backpressure();
        test_forward();
        test_cancel();
        test_reset_midstall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
